// File: rtl/noc2validready_handshake_adapter_if.sv
// Bundles both sides of the ejection adapter: the NoC valid/avail side and the
// valid/ready consumer side, plus the sticky protocol error flag.
//   slave  modport: the adapter (receives flits, drives avail/out/error)
//   master modport: the environment (router port + consumer)
// Signal names keep the adapter-relative _i/_o suffixes.
interface noc2validready_handshake_adapter_if #(
  parameter int unsigned FlitWidth               = 64,
  parameter int unsigned NumberOfVirtualChannels = 2,
  parameter int unsigned VirtualChannelIdWidth   = 1
);
  logic                               valid_i;
  logic [FlitWidth-1:0]               data_i;
  logic [VirtualChannelIdWidth-1:0]   virtual_channel_id_i;
  logic [NumberOfVirtualChannels-1:0] avail_o;
  logic                               valid_o;
  logic                               ready_i;
  logic [FlitWidth-1:0]               data_o;
  logic [VirtualChannelIdWidth-1:0]   virtual_channel_id_o;
  logic                               protocol_error_o;

  modport slave (
    input  valid_i, data_i, virtual_channel_id_i, ready_i,
    output avail_o, valid_o, data_o, virtual_channel_id_o, protocol_error_o
  );

  modport master (
    output valid_i, data_i, virtual_channel_id_i, ready_i,
    input  avail_o, valid_o, data_o, virtual_channel_id_o, protocol_error_o
  );
endinterface

// File: rtl/noc2validready_handshake_adapter.sv
// Ejection adapter: NoC valid/avail flits -> per-VC FIFOs -> single valid/ready
// output with round-robin arbitration over non-empty VCs.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus_io : adapter side of the handshake interface
//            valid_i/data_i/virtual_channel_id_i in, avail_o out (registered),
//            valid_o/data_o/virtual_channel_id_o out, ready_i in,
//            protocol_error_o out (sticky until reset)
module noc2validready_handshake_adapter #(
  parameter int unsigned FlitWidth               = 64,
  parameter int unsigned NumberOfVirtualChannels = 2,
  parameter int unsigned VirtualChannelIdWidth   = 1,
  parameter int unsigned FifoDepth               = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  noc2validready_handshake_adapter_if.slave    bus_io
);

  localparam int unsigned NumVc = NumberOfVirtualChannels;
  localparam int unsigned VcW   = VirtualChannelIdWidth;
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

  logic [FlitWidth-1:0] mem_q [NumVc][FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q [NumVc];
  logic [PtrW-1:0]      wr_ptr_d [NumVc];
  logic [PtrW-1:0]      rd_ptr_q [NumVc];
  logic [PtrW-1:0]      rd_ptr_d [NumVc];
  logic [CntW-1:0]      occ_q    [NumVc];
  logic [CntW-1:0]      occ_d    [NumVc];
  logic [NumVc-1:0]     avail_q, avail_d;
  logic [NumVc-1:0]     nonempty, push_vec, pop_vec;
  logic [VcW-1:0]       rr_q, rr_d;
  logic [VcW-1:0]       lock_vc_q, lock_vc_d;
  logic [VcW-1:0]       grant, search_vc;
  lock_state_e          state_q, state_d;
  logic                 perr_q, perr_d;
  logic                 vc_in_range, push_ok, pop, out_valid, found;
  int unsigned          idx;

  // Input acceptance: only a flit offered to an in-range VC with avail high is stored.
  always_comb begin
    vc_in_range = 32'(bus_io.virtual_channel_id_i) < NumVc;
    push_ok     = bus_io.valid_i && vc_in_range && avail_q[bus_io.virtual_channel_id_i];
    perr_d      = perr_q | (bus_io.valid_i & ~push_ok);
  end

  always_comb begin
    for (int unsigned v = 0; v < NumVc; v++) begin
      nonempty[v] = occ_q[v] != '0;
      push_vec[v] = push_ok && (bus_io.virtual_channel_id_i == VcW'(v));
      pop_vec[v]  = pop && (grant == VcW'(v));
    end
  end

  // Cyclic search for the first non-empty VC starting at the RR pointer.
  always_comb begin
    search_vc = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NumVc; i++) begin
      idx = (32'(rr_q) + i) % NumVc;
      if (!found && nonempty[idx]) begin
        found     = 1'b1;
        search_vc = VcW'(idx);
      end
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StUnlocked;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // Lock FSM: next state. A stalled offer freezes the grant until the handshake.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    unique case (state_q)
      StUnlocked: begin
        if (out_valid && !bus_io.ready_i) begin
          state_d   = StLocked;
          lock_vc_d = grant;
        end
      end
      StLocked: begin
        if (bus_io.ready_i) state_d = StUnlocked;
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Lock FSM: outputs (grant selection).
  always_comb begin
    unique case (state_q)
      StLocked: grant = lock_vc_q;
      default:  grant = search_vc;
    endcase
  end

  always_comb begin
    out_valid = |nonempty;
    pop       = out_valid && bus_io.ready_i;
    rr_d      = rr_q;
    if (pop) begin
      rr_d = (32'(grant) == NumVc - 1) ? '0 : grant + VcW'(1);
    end
  end

  // avail is computed from next occupancy, so a pop never raises it early.
  always_comb begin
    for (int unsigned v = 0; v < NumVc; v++) begin
      occ_d[v]    = occ_q[v] + CntW'(push_vec[v]) - CntW'(pop_vec[v]);
      wr_ptr_d[v] = wr_ptr_q[v] + PtrW'(push_vec[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PtrW'(pop_vec[v]);
      avail_d[v]  = occ_d[v] < CntW'(FifoDepth);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        occ_q[v]    <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      avail_q <= '0;
      rr_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        occ_q[v]    <= occ_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
      avail_q <= avail_d;
      rr_q    <= rr_d;
      perr_q  <= perr_d;
    end
  end

  // Storage needs no reset: contents are only visible while occupancy is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[bus_io.virtual_channel_id_i][wr_ptr_q[bus_io.virtual_channel_id_i]] <= bus_io.data_i;
    end
  end

  always_comb begin
    bus_io.avail_o          = avail_q;
    bus_io.valid_o          = out_valid;
    bus_io.protocol_error_o = perr_q;
    bus_io.data_o           = '0;
    bus_io.virtual_channel_id_o = '0;
    if (out_valid) begin
      bus_io.data_o               = mem_q[grant][rd_ptr_q[grant]];
      bus_io.virtual_channel_id_o = grant;
    end
  end

endmodule
